// File: rtl/ws2812_tx.sv
// WS2812 single-wire transmitter: pulse-width codes a packed GRB frame MSB first, then holds the line low to latch.
// dout/busy change on the accepting edge itself; extra start edges while busy are dropped, never queued.
module ws2812_tx #(
  parameter int NUM_LEDS  = 5,
  parameter int T0H       = 40,
  parameter int T1H       = 80,
  parameter int TBIT      = 125,
  parameter int RESET_CYC = 30000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [24*NUM_LEDS-1:0]  grb_in,
  output logic                    dout,
  output logic                    busy,
  output logic                    done
);

  localparam int NBITS  = 24 * NUM_LEDS;
  localparam int TMAX   = (TBIT > RESET_CYC) ? TBIT : RESET_CYC;
  localparam int TCNT_W = $clog2(TMAX);
  localparam int BCNT_W = $clog2(NBITS) + 1;

  localparam logic [TCNT_W-1:0] TBIT_LAST = TCNT_W'(TBIT - 1);
  localparam logic [TCNT_W-1:0] RST_LAST  = TCNT_W'(RESET_CYC - 1);
  localparam logic [TCNT_W-1:0] T0H_V     = TCNT_W'(T0H);
  localparam logic [TCNT_W-1:0] T1H_V     = TCNT_W'(T1H);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [NBITS-1:0]    sreg_q, sreg_d;
  logic                start_q;
  logic                armed_q;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_edge;
  logic [TCNT_W-1:0]   thresh;

  // armed_q blocks a level held high across reset release from posing as a fresh edge.
  assign start_edge = start & ~start_q & armed_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          sreg_d  = grb_in;
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tcnt_q == TBIT_LAST) begin
          tcnt_d = '0;
          sreg_d = {sreg_q[NBITS-2:0], 1'b0};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BIT_LAST) state_d = LATCH;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      LATCH: begin
        if (tcnt_q == RST_LAST) begin
          tcnt_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // dout is registered, so it is derived from next-cycle bit/count to stay aligned with tcnt.
    thresh = sreg_d[NBITS-1] ? T1H_V : T0H_V;
    dout_d = (state_d == SEND) && (tcnt_d < thresh);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      start_q <= start;
      armed_q <= 1'b1;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
